// File: rtl/twenty_bit_divider_controller_pkg.sv
// Shared definitions for the 20-bit restoring divider: FSM encoding and sizing constants.
package twenty_bit_divider_controller_pkg;

  localparam int DIV_WIDTH = 20;
  localparam int DIV_ITER  = 20;
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT_DEFAULT = 20'hFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } div_state_t;

endpackage

// File: rtl/twenty_bit_subtractor.sv
// Combinational 20-bit ripple-borrow subtractor: d = i0 - i1, bout set when i0 < i1.
module twenty_bit_subtractor (
  input  logic [19:0] i0,
  input  logic [19:0] i1,
  output logic [19:0] d,
  output logic        bout
);

  logic [20:0] borrow;

  assign borrow[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_bit
      assign d[gi]          = i0[gi] ^ i1[gi] ^ borrow[gi];
      assign borrow[gi + 1] = (~i0[gi] & i1[gi]) | (~(i0[gi] ^ i1[gi]) & borrow[gi]);
    end
  endgenerate

  assign bout = borrow[20];

endmodule

// File: rtl/twenty_bit_divider_controller.sv
// Multi-cycle unsigned 20-bit restoring divider; one shift/trial-subtract per clock
// through a single shared subtractor, with start/busy/done handshake and divide-by-zero flag.
module twenty_bit_divider_controller
  import twenty_bit_divider_controller_pkg::*;
#(
  parameter int                WIDTH        = DIV_WIDTH,
  parameter logic [WIDTH-1:0]  DBZ_QUOTIENT = DBZ_QUOTIENT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  div_state_t       state_reg;
  logic [4:0]       count_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] sub_d;
  logic             sub_bout;
  logic             ok;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  // When trial[20] is set the trial already exceeds the divisor, and the low 20
  // bits of the difference are exact because the true result is below divisor.
  assign trial = {r_reg, q_reg[WIDTH-1]};

  twenty_bit_subtractor u_sub (
    .i0   (trial[WIDTH-1:0]),
    .i1   (divisor_reg),
    .d    (sub_d),
    .bout (sub_bout)
  );

  assign ok        = trial[WIDTH] | ~sub_bout;
  assign r_next    = ok ? sub_d : trial[WIDTH-1:0];
  assign q_next    = {q_reg[WIDTH-2:0], ok};
  assign last_iter = (count_reg == 5'(DIV_ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      q_reg         <= '0;
      r_reg         <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          // A divide-by-zero completes in IDLE; skipping the cycle right after it
          // keeps done from ever being high on two consecutive cycles.
          if (start && !done_reg) begin
            if (divisor == '0) begin
              quotient_reg  <= DBZ_QUOTIENT;
              remainder_reg <= dividend;
              dbz_reg       <= 1'b1;
              done_reg      <= 1'b1;
            end else begin
              divisor_reg <= divisor;
              q_reg       <= dividend;
              r_reg       <= '0;
              count_reg   <= '0;
              busy_reg    <= 1'b1;
              dbz_reg     <= 1'b0;
              state_reg   <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          r_reg <= r_next;
          q_reg <= q_next;
          if (last_iter) begin
            quotient_reg  <= q_next;
            remainder_reg <= r_next;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_DONE;
          end else begin
            count_reg <= count_reg + 5'd1;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign dbz       = dbz_reg;

endmodule
